// File: rtl/bsram_arbiter.sv
// rtl/bsram_arbiter.sv - round-robin two-port arbiter and sequencer for a single-port block RAM
// Grants at most one access per cycle, owns every RAM pin and returns read data with a fixed latency.
module bsram_arbiter #(
  parameter int AW           = 7,
  parameter int DW           = 18,
  parameter int READ_LATENCY = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          mem_ce,
  output logic          mem_oce,
  output logic          mem_wre,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);
  localparam int PL = READ_LATENCY + 1;

  typedef enum logic {PTR_A = 1'b0, PTR_B = 1'b1} ptr_e;
  ptr_e ptr_q, ptr_d;

  logic          accept;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  logic          ce_q, ce_d, wre_q, wre_d, oce_q;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] din_q, din_d;
  logic [PL-1:0] pv_q, pv_d, pid_q, pid_d;
  logic          a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic [DW-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!reset) begin
      if (a_req && (!b_req || ptr_q == PTR_A)) a_gnt = 1'b1;
      else if (b_req)                          b_gnt = 1'b1;
    end
  end

  assign accept    = a_gnt | b_gnt;
  assign sel_we    = a_gnt ? a_we    : b_we;
  assign sel_addr  = a_gnt ? a_addr  : b_addr;
  assign sel_wdata = a_gnt ? a_wdata : b_wdata;

  // pv/pid track each accepted read until the RAM data is ready at the last stage
  always_comb begin
    ptr_d = ptr_q;
    if (a_gnt)      ptr_d = PTR_B;
    else if (b_gnt) ptr_d = PTR_A;
    ce_d  = accept;
    wre_d = accept & sel_we;
    adr_d = adr_q;
    din_d = din_q;
    if (accept) begin
      adr_d = sel_addr;
      din_d = sel_we ? sel_wdata : '0;
    end
    pv_d       = {pv_q[PL-2:0], accept & ~sel_we};
    pid_d      = {pid_q[PL-2:0], b_gnt};
    a_rvalid_d = pv_q[PL-1] & ~pid_q[PL-1];
    b_rvalid_d = pv_q[PL-1] & pid_q[PL-1];
    a_rdata_d  = a_rvalid_d ? mem_dout : a_rdata_q;
    b_rdata_d  = b_rvalid_d ? mem_dout : b_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q      <= PTR_A;
      ce_q       <= 1'b0;
      wre_q      <= 1'b0;
      oce_q      <= 1'b0;
      adr_q      <= '0;
      din_q      <= '0;
      pv_q       <= '0;
      pid_q      <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      ptr_q      <= ptr_d;
      ce_q       <= ce_d;
      wre_q      <= wre_d;
      oce_q      <= 1'b1;
      adr_q      <= adr_d;
      din_q      <= din_d;
      pv_q       <= pv_d;
      pid_q      <= pid_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  assign mem_ce   = ce_q;
  assign mem_wre  = wre_q;
  assign mem_oce  = oce_q;
  assign mem_adr  = adr_q;
  assign mem_din  = din_q;
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_bsram_arbiter.sv
// tb/tb_bsram_arbiter.sv - randomized bench for bsram_arbiter at READ_LATENCY 1 and 2
// Both instances see the same requests; a transaction-level model predicts grants, RAM pins and responses.
module tb_bsram_arbiter;
  localparam int AW = 7;
  localparam int DW = 18;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;

  logic          a_gnt [2], b_gnt [2], a_rvalid [2], b_rvalid [2];
  logic          mem_ce [2], mem_oce [2], mem_wre [2];
  logic [DW-1:0] a_rdata [2], b_rdata [2], mem_din [2], mem_dout [2];
  logic [AW-1:0] mem_adr [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic [DW-1:0] ram [2**AW];
    logic [DW-1:0] q1, q2;

    bsram_arbiter #(.AW(AW), .DW(DW), .READ_LATENCY(g + 1)) dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt[g]), .a_rvalid(a_rvalid[g]), .a_rdata(a_rdata[g]),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt[g]), .b_rvalid(b_rvalid[g]), .b_rdata(b_rdata[g]),
      .mem_ce(mem_ce[g]), .mem_oce(mem_oce[g]), .mem_wre(mem_wre[g]),
      .mem_adr(mem_adr[g]), .mem_din(mem_din[g]), .mem_dout(mem_dout[g])
    );

    // single-port RAM: q1 is the array output, q2 the optional output register
    always @(posedge clk) begin
      if (mem_ce[g]) begin
        if (mem_wre[g]) ram[mem_adr[g]] <= mem_din[g];
        else            q1 <= ram[mem_adr[g]];
      end
      if (mem_oce[g]) q2 <= q1;
    end
    assign mem_dout[g] = (g == 0) ? q1 : q2;
  end

  typedef struct {
    logic          port_b;
    logic [DW-1:0] data;
    int            acc;
  } rd_t;

  int            checks = 0;
  int            errors = 0;
  int            n;
  logic          ptr_b, acc_a, acc_b, pa, pb;
  logic          e_ce, e_wre, e_oce;
  logic [AW-1:0] e_adr;
  logic [DW-1:0] e_din;
  logic [DW-1:0] shadow [2**AW];
  logic [DW-1:0] e_ard [2], e_brd [2];
  rd_t           rq [$];
  int            rd_idx [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, n);
    end
  endtask

  task automatic drive(input logic ar, input logic aw, input int aad, input int awd,
                       input logic br, input logic bw, input int bad, input int bwd);
    a_req = ar; a_we = aw; a_addr = AW'(aad); a_wdata = DW'(awd);
    b_req = br; b_we = bw; b_addr = AW'(bad); b_wdata = DW'(bwd);
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 7));
    return AW'($urandom_range(0, 2**AW - 1));
  endfunction

  // One clock: compare all outputs against the model, then advance the model across the edge.
  task automatic step();
    logic          eag, ebg, eav, ebv, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    @(negedge clk);
    eag = !reset && a_req && (!b_req || !ptr_b);
    ebg = !reset && b_req && !eag;
    for (int k = 0; k < 2; k++) begin
      eav = 1'b0;
      ebv = 1'b0;
      if (rd_idx[k] < rq.size() && rq[rd_idx[k]].acc + k + 3 == n) begin
        if (rq[rd_idx[k]].port_b) begin ebv = 1'b1; e_brd[k] = rq[rd_idx[k]].data; end
        else                      begin eav = 1'b1; e_ard[k] = rq[rd_idx[k]].data; end
        rd_idx[k]++;
      end
      check_eq($sformatf("L%0d a_gnt", k + 1),    32'(a_gnt[k]),    32'(eag));
      check_eq($sformatf("L%0d b_gnt", k + 1),    32'(b_gnt[k]),    32'(ebg));
      check_eq($sformatf("L%0d a_rvalid", k + 1), 32'(a_rvalid[k]), 32'(eav));
      check_eq($sformatf("L%0d b_rvalid", k + 1), 32'(b_rvalid[k]), 32'(ebv));
      check_eq($sformatf("L%0d a_rdata", k + 1),  32'(a_rdata[k]),  32'(e_ard[k]));
      check_eq($sformatf("L%0d b_rdata", k + 1),  32'(b_rdata[k]),  32'(e_brd[k]));
      check_eq($sformatf("L%0d mem_ce", k + 1),   32'(mem_ce[k]),   32'(e_ce));
      check_eq($sformatf("L%0d mem_wre", k + 1),  32'(mem_wre[k]),  32'(e_wre));
      check_eq($sformatf("L%0d mem_oce", k + 1),  32'(mem_oce[k]),  32'(e_oce));
      check_eq($sformatf("L%0d mem_adr", k + 1),  32'(mem_adr[k]),  32'(e_adr));
      check_eq($sformatf("L%0d mem_din", k + 1),  32'(mem_din[k]),  32'(e_din));
    end
    if (reset) begin
      ptr_b = 1'b0; acc_a = 1'b0; acc_b = 1'b0;
      e_ce = 1'b0; e_wre = 1'b0; e_oce = 1'b0; e_adr = '0; e_din = '0;
      for (int k = 0; k < 2; k++) begin
        e_ard[k] = '0; e_brd[k] = '0; rd_idx[k] = rq.size();
      end
    end else begin
      acc_a = eag; acc_b = ebg;
      e_oce = 1'b1; e_ce = eag | ebg; e_wre = 1'b0;
      if (eag || ebg) begin
        we   = eag ? a_we    : b_we;
        addr = eag ? a_addr  : b_addr;
        wd   = eag ? a_wdata : b_wdata;
        e_wre = we;
        e_adr = addr;
        e_din = we ? wd : '0;
        if (we) shadow[addr] = wd;
        else    rq.push_back(rd_t'{ebg, shadow[addr], n});
        ptr_b = eag;
      end
    end
    n++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    n = 0; ptr_b = 1'b0; acc_a = 1'b0; acc_b = 1'b0; pa = 1'b0; pb = 1'b0;
    e_ce = 1'b0; e_wre = 1'b0; e_oce = 1'b0; e_adr = '0; e_din = '0;
    for (int k = 0; k < 2; k++) begin e_ard[k] = '0; e_brd[k] = '0; rd_idx[k] = 0; end

    drive(1, 0, 3, 0, 1, 0, 4, 0);
    step();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();

    for (int i = 0; i < 3; i++) begin drive(1, 1, i, i + 1, 0, 0, 0, 0); step(); end
    drive(0, 0, 0, 0, 0, 0, 0, 0); repeat (2) step();
    for (int i = 0; i < 3; i++) begin drive(1, 0, i, 0, 0, 0, 0, 0); step(); end
    drive(0, 0, 0, 0, 0, 0, 0, 0); repeat (6) step();
    drive(1, 0, 0, 0, 1, 0, 1, 0); repeat (4) step();
    drive(0, 0, 0, 0, 0, 0, 0, 0); repeat (6) step();
    drive(0, 0, 0, 0, 1, 1, 5, 'h3FFFF); step();
    drive(1, 0, 5, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0); repeat (6) step();

    // reads in flight across a one-cycle reset must never answer
    drive(1, 0, 0, 0, 0, 0, 0, 0); step();
    drive(1, 0, 1, 0, 0, 0, 0, 0); step();
    reset = 1'b1;
    drive(1, 0, 2, 0, 1, 0, 5, 0); step();
    reset = 1'b0;
    repeat (2) step();
    drive(0, 0, 0, 0, 0, 0, 0, 0); repeat (6) step();

    for (int i = 0; i < 2**AW; i++) begin drive(0, 0, 0, 0, 1, 1, i, int'($urandom)); step(); end
    drive(0, 0, 0, 0, 0, 0, 0, 0); repeat (2) step();

    for (int c = 0; c < 2000; c++) begin
      if (!pa && $urandom_range(0, 9) < 6) begin
        pa = 1'b1; a_we = 1'($urandom_range(0, 1)); a_addr = rnd_addr(); a_wdata = DW'($urandom);
      end
      if (!pb && $urandom_range(0, 9) < 6) begin
        pb = 1'b1; b_we = 1'($urandom_range(0, 1)); b_addr = rnd_addr(); b_wdata = DW'($urandom);
      end
      a_req = pa;
      b_req = pb;
      reset = ($urandom_range(0, 199) == 0);
      step();
      if (acc_a) pa = 1'b0;
      if (acc_b) pb = 1'b0;
    end
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (6) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
